// File: rtl/cache_axi_bridge_pkg.sv
// Request type encodings, AXI constants and FSM state types shared by the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

   localparam logic [2:0] RDT_BYTE = 3'b000;
   localparam logic [2:0] RDT_HALF = 3'b001;
   localparam logic [2:0] RDT_WORD = 3'b010;
   localparam logic [2:0] RDT_LINE = 3'b100;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int         AXI_ID_INST    = 0;
   localparam int         AXI_ID_DATA    = 1;
   localparam int         DEF_LINE_WORDS = 4;

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_e;

   function automatic logic [7:0] req_len(input logic [2:0] rtype, input int line_words);
      return (rtype == RDT_LINE) ? 8'(line_words - 1) : 8'd0;
   endfunction

   function automatic logic [2:0] req_size(input logic [2:0] rtype);
      logic [2:0] size;
      case (rtype)
         RDT_BYTE: size = 3'd0;
         RDT_HALF: size = 3'd1;
         default:  size = 3'd2;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/cache_axi_bridge_line_wr_buffer.sv
// Holds one buffered write (line data, type, wstrb) and sequences its W beats; beat advances on adv_i.
// Outputs are registered-state only and stay stable while wready is low.
module line_wr_buffer
   import cache_axi_bridge_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       load_i,
   input  logic [2:0]                 type_i,
   input  logic [3:0]                 wstrb_i,
   input  logic [32*LINE_WORDS-1:0]   data_i,
   input  logic                       active_i,
   input  logic                       adv_i,
   output logic [31:0]                wdata_o,
   output logic [3:0]                 wstrb_o,
   output logic                       wlast_o
);
   localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   logic [LINE_WORDS-1:0][31:0] data_q;
   logic [2:0]                  type_q;
   logic [3:0]                  wstrb_q;
   logic [BW-1:0]               beat_q;
   logic [BW-1:0]               last_beat;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q  <= '0;
         type_q  <= RDT_BYTE;
         wstrb_q <= '0;
         beat_q  <= '0;
      end else if (load_i) begin
         data_q  <= data_i;
         type_q  <= type_i;
         wstrb_q <= wstrb_i;
         beat_q  <= '0;
      end else if (adv_i) begin
         beat_q  <= beat_q + 1'b1;
      end
   end

   assign last_beat = (type_q == RDT_LINE) ? BW'(LINE_WORDS - 1) : '0;

   // Outputs are forced to zero outside the data phase so an idle bus is quiet.
   assign wdata_o = active_i ? data_q[beat_q] : '0;
   assign wstrb_o = !active_i ? 4'h0 : (type_q == RDT_LINE) ? 4'hf : wstrb_q;
   assign wlast_o = active_i && (beat_q == last_beat);

endmodule

// File: rtl/cache_axi_bridge.sv
// Merges I-cache/D-cache read and D-cache write requests onto one AXI master; AR/AW one cycle after accept.
// Read returns pass straight through; each *_rdy drops while its FSM is busy or a read hits the pending write line.
module cache_axi_bridge
   import cache_axi_bridge_pkg::*;
#(
   parameter int AXI_ID_W   = 4,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      inst_rd_req,
   input  logic [2:0]                inst_rd_type,
   input  logic [31:0]               inst_rd_addr,
   output logic                      inst_rd_rdy,
   output logic                      inst_ret_valid,
   output logic                      inst_ret_last,
   output logic [31:0]               inst_ret_data,
   input  logic                      data_rd_req,
   input  logic [2:0]                data_rd_type,
   input  logic [31:0]               data_rd_addr,
   output logic                      data_rd_rdy,
   output logic                      data_ret_valid,
   output logic                      data_ret_last,
   output logic [31:0]               data_ret_data,
   input  logic                      data_wr_req,
   input  logic [2:0]                data_wr_type,
   input  logic [31:0]               data_wr_addr,
   input  logic [3:0]                data_wr_wstrb,
   input  logic [32*LINE_WORDS-1:0]  data_wr_data,
   output logic                      data_wr_rdy,
   output logic [AXI_ID_W-1:0]       arid,
   output logic [31:0]               araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [AXI_ID_W-1:0]       rid,
   input  logic [31:0]               rdata,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [AXI_ID_W-1:0]       awid,
   output logic [31:0]               awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [31:0]               wdata,
   output logic [3:0]                wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic                      bvalid,
   output logic                      bready
);
   rd_state_e   rd_state_q, rd_state_d;
   logic        rd_turn_q, rd_turn_d;
   logic        rd_owner_q, rd_owner_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [7:0]  rd_len_q, rd_len_d;
   logic [2:0]  rd_size_q, rd_size_d;

   wr_state_e   wr_state_q, wr_state_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_len_q, wr_len_d;
   logic [2:0]  wr_size_q, wr_size_d;

   logic wr_busy, inst_hit, data_hit, inst_acc, data_acc, wr_acc, turn_req, own_data;

   // A read may not overtake a buffered write to the same 16-byte line.
   assign wr_busy  = (wr_state_q != W_IDLE);
   assign inst_hit = wr_busy && (inst_rd_addr[31:4] == wr_addr_q[31:4]);
   assign data_hit = wr_busy && (data_rd_addr[31:4] == wr_addr_q[31:4]);

   assign inst_rd_rdy = (rd_state_q == R_IDLE) && !rd_turn_q && !inst_hit;
   assign data_rd_rdy = (rd_state_q == R_IDLE) &&  rd_turn_q && !data_hit;
   assign data_wr_rdy = (wr_state_q == W_IDLE);

   assign inst_acc = inst_rd_req && inst_rd_rdy;
   assign data_acc = data_rd_req && data_rd_rdy;
   assign wr_acc   = data_wr_req && data_wr_rdy;
   assign turn_req = rd_turn_q ? data_rd_req : inst_rd_req;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state_q <= R_IDLE;
         rd_turn_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         rd_size_q  <= '0;
         wr_state_q <= W_IDLE;
         wr_addr_q  <= '0;
         wr_len_q   <= '0;
         wr_size_q  <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_turn_q  <= rd_turn_d;
         rd_owner_q <= rd_owner_d;
         rd_addr_q  <= rd_addr_d;
         rd_len_q   <= rd_len_d;
         rd_size_q  <= rd_size_d;
         wr_state_q <= wr_state_d;
         wr_addr_q  <= wr_addr_d;
         wr_len_q   <= wr_len_d;
         wr_size_q  <= wr_size_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_turn_d  = rd_turn_q;
      rd_owner_d = rd_owner_q;
      rd_addr_d  = rd_addr_q;
      rd_len_d   = rd_len_q;
      rd_size_d  = rd_size_q;
      case (rd_state_q)
         R_IDLE: begin
            if (inst_acc || data_acc) begin
               rd_owner_d = data_acc;
               rd_addr_d  = data_acc ? data_rd_addr : inst_rd_addr;
               rd_len_d   = req_len(data_acc ? data_rd_type : inst_rd_type, LINE_WORDS);
               rd_size_d  = req_size(data_acc ? data_rd_type : inst_rd_type);
               rd_state_d = R_AR;
            end else if (!turn_req) begin
               rd_turn_d = ~rd_turn_q;
            end
         end
         R_AR:    if (arready) rd_state_d = R_DATA;
         R_DATA: begin
            if (rvalid && rlast) begin
               rd_state_d = R_IDLE;
               rd_turn_d  = ~rd_owner_q;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wr_addr_d  = wr_addr_q;
      wr_len_d   = wr_len_q;
      wr_size_d  = wr_size_q;
      case (wr_state_q)
         W_IDLE: begin
            if (wr_acc) begin
               wr_addr_d  = data_wr_addr;
               wr_len_d   = req_len(data_wr_type, LINE_WORDS);
               wr_size_d  = req_size(data_wr_type);
               wr_state_d = W_AW;
            end
         end
         W_AW:    if (awready) wr_state_d = W_DATA;
         W_DATA:  if (wready && wlast) wr_state_d = W_B;
         W_B:     if (bvalid) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   assign arvalid = (rd_state_q == R_AR);
   assign arid    = rd_owner_q ? AXI_ID_W'(AXI_ID_DATA) : AXI_ID_W'(AXI_ID_INST);
   assign araddr  = rd_addr_q;
   assign arlen   = rd_len_q;
   assign arsize  = rd_size_q;
   assign arburst = arvalid ? AXI_BURST_INCR : 2'b00;
   assign rready  = (rd_state_q == R_DATA);

   // Return beats are steered combinationally to whichever side owns the burst.
   assign own_data       = rd_owner_q;
   assign inst_ret_valid = rready && !own_data && rvalid;
   assign inst_ret_last  = inst_ret_valid && rlast;
   assign inst_ret_data  = (rready && !own_data) ? rdata : '0;
   assign data_ret_valid = rready && own_data && rvalid;
   assign data_ret_last  = data_ret_valid && rlast;
   assign data_ret_data  = (rready && own_data) ? rdata : '0;

   assign awvalid = (wr_state_q == W_AW);
   assign awid    = awvalid ? AXI_ID_W'(AXI_ID_DATA) : '0;
   assign awaddr  = wr_addr_q;
   assign awlen   = wr_len_q;
   assign awsize  = wr_size_q;
   assign awburst = awvalid ? AXI_BURST_INCR : 2'b00;
   assign wvalid  = (wr_state_q == W_DATA);
   assign bready  = (wr_state_q == W_B);

   line_wr_buffer #(
      .LINE_WORDS (LINE_WORDS)
   ) u_line_wr_buffer (
      .clk      (clk),
      .resetn   (resetn),
      .load_i   (wr_acc),
      .type_i   (data_wr_type),
      .wstrb_i  (data_wr_wstrb),
      .data_i   (data_wr_data),
      .active_i (wvalid),
      .adv_i    (wvalid && wready),
      .wdata_o  (wdata),
      .wstrb_o  (wstrb),
      .wlast_o  (wlast)
   );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scoreboard bench for cache_axi_bridge: expected R returns and W beats are queued when stimulus is driven.
module tb_cache_axi_bridge;
   localparam int IDW = 4;

   typedef struct {
      logic [31:0] dat;
      logic [3:0]  strb;
      logic        last;
   } wexp_t;

   logic clk, resetn;
   logic inst_rd_req, inst_rd_rdy, inst_ret_valid, inst_ret_last;
   logic [2:0] inst_rd_type;
   logic [31:0] inst_rd_addr, inst_ret_data;
   logic data_rd_req, data_rd_rdy, data_ret_valid, data_ret_last;
   logic [2:0] data_rd_type;
   logic [31:0] data_rd_addr, data_ret_data;
   logic data_wr_req, data_wr_rdy;
   logic [2:0] data_wr_type;
   logic [31:0] data_wr_addr;
   logic [3:0] data_wr_wstrb;
   logic [127:0] data_wr_data;
   logic [IDW-1:0] arid, rid, awid;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [7:0] arlen, awlen;
   logic [2:0] arsize, awsize;
   logic [1:0] arburst, awburst;
   logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
   logic [3:0] wstrb;
   logic wlast, wvalid, wready, bvalid, bready;

   int n_cmp = 0;
   int n_err = 0;
   int inst_beats = 0;
   int data_beats = 0;
   logic [32:0] exp_inst[$];
   logic [32:0] exp_data[$];
   wexp_t exp_w[$];
   logic [32:0] rx;
   wexp_t wx;

   cache_axi_bridge #(.AXI_ID_W(IDW), .LINE_WORDS(4)) dut (
      .clk(clk), .resetn(resetn),
      .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
      .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
      .inst_ret_data(inst_ret_data),
      .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
      .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
      .data_ret_data(data_ret_data),
      .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
      .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1);
   end

   // Scoreboard: pops an expectation on every return beat and every W handshake.
   always @(negedge clk) begin
      #2;
      if (inst_ret_valid === 1'b1) begin
         n_cmp++;
         inst_beats++;
         if (exp_inst.size() == 0) begin
            n_err++;
            $display("FAIL inst_ret unexpected beat got=%h required=none", inst_ret_data);
         end else begin
            rx = exp_inst.pop_front();
            if ({inst_ret_data, inst_ret_last} !== rx) begin
               n_err++;
               $display("FAIL inst_ret got data=%h last=%b required data=%h last=%b",
                        inst_ret_data, inst_ret_last, rx[32:1], rx[0]);
            end
         end
      end
      if (data_ret_valid === 1'b1) begin
         n_cmp++;
         data_beats++;
         if (exp_data.size() == 0) begin
            n_err++;
            $display("FAIL data_ret unexpected beat got=%h required=none", data_ret_data);
         end else begin
            rx = exp_data.pop_front();
            if ({data_ret_data, data_ret_last} !== rx) begin
               n_err++;
               $display("FAIL data_ret got data=%h last=%b required data=%h last=%b",
                        data_ret_data, data_ret_last, rx[32:1], rx[0]);
            end
         end
      end
      if (wvalid === 1'b1 && wready === 1'b1) begin
         n_cmp++;
         if (exp_w.size() == 0) begin
            n_err++;
            $display("FAIL w_beat unexpected got wdata=%h required=none", wdata);
         end else begin
            wx = exp_w.pop_front();
            if (wdata !== wx.dat || wstrb !== wx.strb || wlast !== wx.last) begin
               n_err++;
               $display("FAIL w_beat got wdata=%h wstrb=%b wlast=%b required wdata=%h wstrb=%b wlast=%b",
                        wdata, wstrb, wlast, wx.dat, wx.strb, wx.last);
            end
         end
      end
   end

   // Called at a falling edge; returns 1 ns into the AR cycle after checking the AR fields.
   task automatic issue_read(input bit side, input logic [31:0] addr, input logic [2:0] typ,
                             output int waited);
      logic [7:0] elen;
      logic [2:0] esize;
      elen  = (typ == 3'b100) ? 8'd3 : 8'd0;
      esize = (typ == 3'b001) ? 3'd1 : (typ == 3'b000) ? 3'd0 : 3'd2;
      if (side) begin
         data_rd_req = 1'b1; data_rd_addr = addr; data_rd_type = typ;
      end else begin
         inst_rd_req = 1'b1; inst_rd_addr = addr; inst_rd_type = typ;
      end
      waited = 0;
      #1;
      while (!(side ? data_rd_rdy : inst_rd_rdy) && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      n_cmp++;
      if (waited >= 40) begin
         n_err++;
         $display("FAIL rd_accept side=%0d rdy stayed 0, required 1 within 40 cycles", side);
      end
      @(negedge clk);
      if (side) data_rd_req = 1'b0; else inst_rd_req = 1'b0;
      #1;
      n_cmp++;
      if (arvalid !== 1'b1 || araddr !== addr || arlen !== elen || arsize !== esize ||
          arid !== {3'b000, side} || arburst !== 2'b01) begin
         n_err++;
         $display("FAIL ar_fields got v=%b a=%h len=%0d size=%0d id=%0d burst=%b required v=1 a=%h len=%0d size=%0d id=%0d burst=01",
                  arvalid, araddr, arlen, arsize, arid, arburst, addr, elen, esize, side);
      end
   endtask

   // Called 1 ns into the AR cycle; completes the AR handshake and plays n R beats back-to-back.
   task automatic read_data(input bit side, input logic [127:0] words, input int n);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < n; i++) begin
         rvalid = 1'b1;
         rdata  = words[32*i +: 32];
         rlast  = (i == n - 1);
         rid    = {3'b000, side};
         if (side) exp_data.push_back({rdata, rlast});
         else      exp_inst.push_back({rdata, rlast});
         #1;
         n_cmp++;
         if (rready !== 1'b1) begin
            n_err++;
            $display("FAIL rready beat=%0d got=%b required=1", i, rready);
         end
         @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   // Called at a falling edge; queues the expected W beats and returns 1 ns into the AW cycle.
   task automatic issue_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                              input logic [127:0] dat);
      int n, w;
      wexp_t e;
      n = (typ == 3'b100) ? 4 : 1;
      for (int i = 0; i < n; i++) begin
         e.dat  = dat[32*i +: 32];
         e.strb = (typ == 3'b100) ? 4'hf : strb;
         e.last = (i == n - 1);
         exp_w.push_back(e);
      end
      data_wr_req = 1'b1; data_wr_addr = addr; data_wr_type = typ;
      data_wr_wstrb = strb; data_wr_data = dat;
      w = 0;
      #1;
      while (!data_wr_rdy && w < 40) begin
         @(negedge clk);
         #1;
         w++;
      end
      n_cmp++;
      if (w >= 40) begin
         n_err++;
         $display("FAIL wr_accept data_wr_rdy stayed 0, required 1 within 40 cycles");
      end
      @(negedge clk);
      data_wr_req = 1'b0;
      #1;
      n_cmp++;
      if (awvalid !== 1'b1 || awaddr !== addr || awlen !== 8'(n - 1) || awsize !== 3'd2 ||
          awid !== 4'd1 || awburst !== 2'b01 || data_wr_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL aw_fields got v=%b a=%h len=%0d size=%0d id=%0d burst=%b wr_rdy=%b required v=1 a=%h len=%0d size=2 id=1 burst=01 wr_rdy=0",
                  awvalid, awaddr, awlen, awsize, awid, awburst, data_wr_rdy, addr, n - 1);
      end
   endtask

   // Called at a falling edge in W_AW; runs AW, W (optionally stalling) and B to completion.
   task automatic run_write(input bit toggle, input bit guard);
      int t;
      bit done;
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      t = 0;
      done = 1'b0;
      while (!done && t < 40) begin
         wready = toggle ? (t % 2 == 1) : 1'b1;
         #1;
         if (guard) begin
            n_cmp++;
            if (data_rd_rdy !== 1'b0) begin
               n_err++;
               $display("FAIL raw_guard data_rd_rdy got=%b required=0 during write", data_rd_rdy);
            end
         end
         n_cmp++;
         if (wvalid !== 1'b1) begin
            n_err++;
            $display("FAIL wvalid cycle=%0d got=%b required=1", t, wvalid);
         end
         if (!wready && exp_w.size() > 0) begin
            n_cmp++;
            if (wdata !== exp_w[0].dat || wlast !== exp_w[0].last) begin
               n_err++;
               $display("FAIL w_stall got wdata=%h wlast=%b required wdata=%h wlast=%b",
                        wdata, wlast, exp_w[0].dat, exp_w[0].last);
            end
         end
         done = wready && (wlast === 1'b1);
         @(negedge clk);
         t++;
      end
      wready = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL w_complete wlast handshake not seen, required within 40 cycles");
      end
      #1;
      n_cmp++;
      if (bready !== 1'b1 || wvalid !== 1'b0 || data_wr_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL b_phase got bready=%b wvalid=%b wr_rdy=%b required 1 0 0", bready, wvalid, data_wr_rdy);
      end
      @(negedge clk);
      bvalid = 1'b1;
      #1;
      n_cmp++;
      if (data_wr_rdy !== 1'b0 || (guard && data_rd_rdy !== 1'b0)) begin
         n_err++;
         $display("FAIL b_wait got wr_rdy=%b rd_rdy=%b required 0 0", data_wr_rdy, data_rd_rdy);
      end
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      n_cmp++;
      if (data_wr_rdy !== 1'b1 || bready !== 1'b0) begin
         n_err++;
         $display("FAIL b_done got wr_rdy=%b bready=%b required 1 0", data_wr_rdy, bready);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({inst_rd_rdy, data_rd_rdy, data_wr_rdy} !== 3'b101) begin
         n_err++;
         $display("FAIL reset_rdy got inst/data/wr=%b required=101", {inst_rd_rdy, data_rd_rdy, data_wr_rdy});
      end
      n_cmp++;
      if ({arvalid, rready, awvalid, wvalid, wlast, bready, inst_ret_valid, data_ret_valid} !== 8'h00 ||
          arburst !== 2'b00 || awid !== 4'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin
         n_err++;
         $display("FAIL reset_outputs got vals=%b arburst=%b awid=%h wdata=%h wstrb=%b required all zero",
                  {arvalid, rready, awvalid, wvalid, wlast, bready, inst_ret_valid, data_ret_valid},
                  arburst, awid, wdata, wstrb);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_line_read;
      int w, b0;
      b0 = inst_beats;
      issue_read(1'b0, 32'h1C00_0040, 3'b100, w);
      read_data(1'b0, {32'h44, 32'h33, 32'h22, 32'h11}, 4);
      n_cmp++;
      if (inst_beats - b0 != 4 || rready !== 1'b0) begin
         n_err++;
         $display("FAIL line_read beats=%0d rready=%b required beats=4 rready=0", inst_beats - b0, rready);
      end
   endtask

   task automatic test_word_write;
      issue_write(32'hBFAF_8000, 3'b010, 4'b0011, 128'h5A5A);
      @(negedge clk);
      run_write(1'b0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_line_write;
      issue_write(32'h0000_0100, 3'b100, 4'b0000, {32'd1, 32'd2, 32'd3, 32'd4});
      @(negedge clk);
      run_write(1'b1, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_raw_guard;
      int w, b0;
      issue_write(32'h0000_0200, 3'b100, 4'b0000, {32'hD4, 32'hC3, 32'hB2, 32'hA1});
      @(negedge clk);
      issue_read(1'b1, 32'h0000_0300, 3'b010, w);
      n_cmp++;
      if (w > 1) begin
         n_err++;
         $display("FAIL other_line_read waited=%0d required<=1 while write pending", w);
      end
      read_data(1'b1, 128'h3003, 1);
      data_rd_req = 1'b1; data_rd_addr = 32'h0000_0208; data_rd_type = 3'b010;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (data_rd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL raw_guard_aw cycle=%0d data_rd_rdy got=%b required=0", i, data_rd_rdy);
         end
         @(negedge clk);
      end
      run_write(1'b0, 1'b1);
      n_cmp++;
      if (data_rd_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL raw_release data_rd_rdy got=%b required=1 after write", data_rd_rdy);
      end
      b0 = data_beats;
      @(negedge clk);
      data_rd_req = 1'b0;
      #1;
      n_cmp++;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_0208 || arid !== 4'd1) begin
         n_err++;
         $display("FAIL raw_ar got v=%b a=%h id=%0d required v=1 a=00000208 id=1", arvalid, araddr, arid);
      end
      read_data(1'b1, 128'h0208, 1);
      n_cmp++;
      if (data_beats - b0 != 1) begin
         n_err++;
         $display("FAIL raw_read beats=%0d required=1", data_beats - b0);
      end
   endtask

   task automatic test_arbitration;
      int w;
      @(negedge clk);
      resetn = 1'b0;
      inst_rd_req = 1'b1; inst_rd_addr = 32'h0000_1000; inst_rd_type = 3'b010;
      data_rd_req = 1'b1; data_rd_addr = 32'h0000_2000; data_rd_type = 3'b010;
      @(negedge clk);
      resetn = 1'b1;
      issue_read(1'b0, 32'h0000_1000, 3'b010, w);
      n_cmp++;
      if (w != 0 || data_rd_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL arb_inst_first waited=%0d data_rd_rdy=%b required 0 0", w, data_rd_rdy);
      end
      read_data(1'b0, 128'h1111, 1);
      issue_read(1'b1, 32'h0000_2000, 3'b010, w);
      n_cmp++;
      if (w != 0) begin
         n_err++;
         $display("FAIL arb_data_next waited=%0d required=0 after inst rlast", w);
      end
      read_data(1'b1, 128'h2222, 1);
   endtask

   task automatic test_reset_mid;
      int w;
      issue_write(32'h0000_0400, 3'b010, 4'b1111, 128'h0400);
      @(negedge clk);
      issue_read(1'b0, 32'h1C00_0080, 3'b100, w);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rvalid = 1'b1; rdata = 32'hE0 + i; rlast = 1'b0; rid = 4'd0;
         exp_inst.push_back({rdata, 1'b0});
         @(negedge clk);
      end
      rvalid = 1'b1; rdata = 32'hE2; rlast = 1'b0;
      #1;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({inst_ret_valid, rready, arvalid, awvalid, wvalid, bready} !== 6'b0) begin
         n_err++;
         $display("FAIL async_reset got ret_v/rready/arv/awv/wv/bready=%b required=000000",
                  {inst_ret_valid, rready, arvalid, awvalid, wvalid, bready});
      end
      rvalid = 1'b0;
      exp_w.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++;
      if (inst_rd_rdy !== 1'b1 || data_wr_rdy !== 1'b1 || arvalid !== 1'b0 || awvalid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release got inst_rdy=%b wr_rdy=%b arv=%b awv=%b required 1 1 0 0",
                  inst_rd_rdy, data_wr_rdy, arvalid, awvalid);
      end
      @(negedge clk);
   endtask

   task automatic test_end;
      n_cmp++;
      if (exp_inst.size() != 0 || exp_data.size() != 0 || exp_w.size() != 0) begin
         n_err++;
         $display("FAIL leftover inst=%0d data=%0d w=%0d required 0 0 0",
                  exp_inst.size(), exp_data.size(), exp_w.size());
      end
   endtask

   initial begin
      resetn = 1'b0;
      inst_rd_req = 1'b0; inst_rd_type = 3'b000; inst_rd_addr = '0;
      data_rd_req = 1'b0; data_rd_type = 3'b000; data_rd_addr = '0;
      data_wr_req = 1'b0; data_wr_type = 3'b000; data_wr_addr = '0;
      data_wr_wstrb = '0; data_wr_data = '0;
      arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      test_reset;
      test_line_read;
      test_word_write;
      test_line_write;
      test_raw_guard;
      test_arbitration;
      test_reset_mid;
      test_end;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Bridges the I-cache and D-cache miss/uncached interfaces onto a single 32-bit AXI master port. It sits directly downstream of both cache instances and consumes their `rd_req`/`wr_req` line and word requests. It returns read beats in `ret_valid`/`ret_last` form. One read and one write may be in flight concurrently, and reads are ordered behind a pending write to the same line.

## Interface
- `AXI_ID_W`, default 4: width of AXI ID fields. The I-side uses ID 0 and the D-side uses ID 1.
- `LINE_WORDS`, default 4: words per cache line, equal to `` `WIDTH``/4. This sets the burst length.
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `inst_rd_req` in 1; `inst_rd_type` in 3; `inst_rd_addr` in 32: I-cache read request.
- `inst_rd_rdy` out 1; `inst_ret_valid` out 1; `inst_ret_last` out 1; `inst_ret_data` out 32: I-cache read handshake and return path.
- `data_rd_req` in 1; `data_rd_type` in 3; `data_rd_addr` in 32: D-cache read request.
- `data_rd_rdy` out 1; `data_ret_valid` out 1; `data_ret_last` out 1; `data_ret_data` out 32: D-cache read handshake and return path.
- `data_wr_req` in 1; `data_wr_type` in 3; `data_wr_addr` in 32; `data_wr_wstrb` in 4; `data_wr_data` in 128: D-cache write request.
- `data_wr_rdy` out 1: D-cache write handshake.
- `arid` out `AXI_ID_W`; `araddr` out 32; `arlen` out 8; `arsize` out 3; `arburst` out 2; `arvalid` out 1: AXI read address channel outputs.
- `arready` in 1: AXI read address ready.
- `rid` in `AXI_ID_W`; `rdata` in 32; `rlast` in 1; `rvalid` in 1: AXI read data inputs.
- `rready` out 1: AXI read data ready.
- `awid` out `AXI_ID_W`; `awaddr` out 32; `awlen` out 8; `awsize` out 3; `awburst` out 2; `awvalid` out 1: AXI write address channel outputs.
- `awready` in 1: AXI write address ready.
- `wdata` out 32; `wstrb` out 4; `wlast` out 1; `wvalid` out 1: AXI write data channel outputs.
- `wready` in 1: AXI write data ready.
- `bvalid` in 1: AXI write response valid.
- `bready` out 1: AXI write response ready.
- `rresp` and `bresp` are not consumed. The lock, cache and prot channel fields are tied off in the top-level wrapper.

## Operation

**Request types**
- `100` is a line: len=`LINE_WORDS`-1, size=2.
- `010` is a word: len=0, size=2.
- `001` is a halfword: len=0, size=1.
- `000` is a byte: len=0, size=0.
- Burst is always INCR (`01`).

**Request handshake rules**
- A request is accepted on the cycle that `*_req` and `*_rdy` are both high.
- Each `*_rdy` depends only on registered state and on the requesting side's own address. It never depends on any `*_req`.

**Read FSM** (states R_IDLE, R_AR, R_DATA)
- A registered bit `rd_turn` selects which side owns R_IDLE: 0 = inst, 1 = data.
- In R_IDLE, only the turn side's `rd_rdy` may be high.
- If the turn side's req is low, `rd_turn` flips the next cycle.
- On accept: latch owner, address, len and size; go to R_AR.
- R_AR: `arvalid`=1. On `arready`, go to R_DATA.
- R_DATA: `rready`=1.
  - `<owner>_ret_valid`=`rvalid`, `<owner>_ret_data`=`rdata`, `<owner>_ret_last`=`rvalid`&`rlast`.
  - The non-owner's `ret_valid` is 0.
  - On `rvalid`&`rlast`: go to R_IDLE and point `rd_turn` at the other side.

**Read-after-write guard**
- A side's `rd_rdy` is forced low while the write FSM is not in W_IDLE and `rd_addr[31:4]` equals the buffered `wr_addr[31:4]`.
- Reads to other lines proceed concurrently with the write.

**Write FSM** (states W_IDLE, W_AW, W_DATA, W_B)
- `data_wr_rdy` = (state == W_IDLE).
- On accept: latch type, addr, wstrb and the 128-bit data; clear the beat counter; go to W_AW.
- W_AW: `awvalid`=1, `awid`=1. On `awready`, go to W_DATA.
- W_DATA: `wvalid`=1.
  - `wdata` = data word[beat], with beat 0 = bits [31:0].
  - `wstrb` = 4'hf for lines; `data_wr_wstrb` otherwise.
  - `wlast` = (beat == len).
  - The beat counter increments on `wready`. On `wready`&`wlast`, go to W_B.
- W_B: `bready`=1. On `bvalid`, go to W_IDLE.

**Reset**
- All FSMs go to idle, `rd_turn`=0, counters are cleared.
- All outputs are 0, except `inst_rd_rdy`=1 and `data_wr_rdy`=1.
- Reset mid-transaction abandons the transaction. No completion is generated.

## Timing
- Read accept at cycle N: `arvalid` high at N+1 and held until `arready`.
- Return beats are combinational pass-through: `ret_valid` is high in the same cycle as `rvalid`.
- A new read can be accepted on the cycle after the `rlast` beat.
- Write accept at N: `awvalid` high at N+1.
- First `wvalid` is the cycle after the `awready` handshake.
- `data_wr_rdy` rises the cycle after the `bvalid` handshake.
- Minimum write occupancy is 3 + `LINE_WORDS` cycles.
- `rd_turn` flip on an idle turn: worst-case added read latency is 1 cycle.
- Read and write FSMs are fully independent apart from the address guard.
- Held channel signals (`*valid`, addresses, `wdata`) stay stable while stalled by a low `*ready`.

## Structure
- Add the following to `cache.vh`:
  - type codes `RDT_BYTE/HALF/WORD/LINE`;
  - `AXI_BURST_INCR`;
  - `AXI_ID_INST` = 0 and `AXI_ID_DATA` = 1;
  - `LINE_WORDS`.
- One sub-module, `line_wr_buffer`. It holds the 128-bit line, type and wstrb, keeps the beat counter, and drives `wdata`, `wstrb` and `wlast`.

## Test plan
- I-cache line read of 0x1C000040 with `arready` immediate and R beats 11,22,33,44 back-to-back. Required: `arlen`=3, `arsize`=2, `arid`=0; `inst_ret_valid` high 4 cycles; `inst_ret_last` only on 44.
- D-cache uncached word write of 0xBFAF8000, `wstrb`=4'b0011, data 0x5A5A. Required: `awlen`=0, a single W beat with `wstrb`=0011 and `wlast`=1; `data_wr_rdy` low until the cycle after `bvalid`.
- Line write of 0x100 (data 4,3,2,1 at words 0..3) with `wready` toggling every other cycle. Required: `wdata` sequence 4,3,2,1; `wlast` on beat 3 only; signals stable during stalls.
- Line write to 0x200 pending, then D read of 0x208. Required: `data_rd_rdy` low until the write completes. A D read of 0x300 in parallel is accepted immediately.
- Both sides request in the same cycle after reset. Required: inst is served first, then data. The data read is accepted within 1 cycle of the inst `rlast`.
- Assert `resetn` low during R_DATA beat 2. Required: all valids drop asynchronously; after release, both FSMs are idle and `inst_rd_rdy`=1.
